// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the datapath and the multiply/divide unit (div_by_zero exists when MDU_DIVZERO_FLAG_EN is defined)

interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_DIVZERO_FLAG_EN
    logic             div_by_zero;

    modport master (
        output start, op, reg_a, reg_b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, reg_a, reg_b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo, div_by_zero
    );
`else
    modport master (
        output start, op, reg_a, reg_b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, reg_a, reg_b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO (optional div_by_zero output via MDU_DIVZERO_FLAG_EN)

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_mag;      // |multiplicand| / |dividend| (raw value for unsigned ops)
    logic [WIDTH-1:0]     b_mag;      // |multiplier| / |divisor|
    logic [2*WIDTH-1:0]   acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic                 neg_q;      // product / quotient must be negated
    logic                 neg_r;      // dividend was negative: remainder follows it
    logic                 b_zero;     // divisor was zero when sampled
    logic [CNT_W-1:0]     cnt;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
`ifdef MDU_DIVZERO_FLAG_EN
    logic                 dz_r;
`endif

    logic                 is_signed_in;
    logic                 a_neg_in;
    logic                 b_neg_in;
    logic [WIDTH-1:0]     a_abs_in;
    logic [WIDTH-1:0]     b_abs_in;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 unused_div_bit;

    // Operand conditioning at start: signed ops iterate on magnitudes
    always_comb begin
        is_signed_in = ~bus.op[0];
        a_neg_in     = is_signed_in & bus.reg_a[WIDTH-1];
        b_neg_in     = is_signed_in & bus.reg_b[WIDTH-1];
        a_abs_in     = a_neg_in ? -bus.reg_a : bus.reg_a;
        b_abs_in     = b_neg_in ? -bus.reg_b : bus.reg_b;
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
        acc_next  = acc;
        if (op_r[1]) begin
            if (!div_diff[WIDTH+1]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied on the FIX edge; rem_fix of a_mag also rebuilds the raw dividend
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (b_zero) begin
            rem_fix = neg_r ? -a_mag : a_mag;
        end
    end

    // A remainder below the divisor never needs the extra diff bit
    assign unused_div_bit = div_diff[WIDTH];

    // Control FSM, iteration datapath and HI/LO ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_r   <= 2'b00;
            a_mag  <= '0;
            b_mag  <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
            dz_r   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
                    dz_r   <= 1'b0;
`endif
                    if (bus.wr_hi) begin
                        hi_r <= bus.wr_data;
                    end
                    if (bus.wr_lo) begin
                        lo_r <= bus.wr_data;
                    end
                    if (bus.start) begin
                        op_r   <= bus.op;
                        a_mag  <= a_abs_in;
                        b_mag  <= b_abs_in;
                        acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs_in : b_abs_in)};
                        neg_q  <= a_neg_in ^ b_neg_in;
                        neg_r  <= a_neg_in;
                        b_zero <= (bus.reg_b == '0);
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (op_r[1]) begin
                        hi_r <= rem_fix;
                        lo_r <= b_zero ? '1 : quo_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
`ifdef MDU_DIVZERO_FLAG_EN
                    dz_r   <= op_r[1] & b_zero;
`endif
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
`ifdef MDU_DIVZERO_FLAG_EN
    assign bus.div_by_zero = dz_r;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit against an arithmetic reference model

module tb_mult_div_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) mdu_if ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mdu_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} straight from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sp;
        int         sa;
        int         sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {r, q};
            end
        endcase
    endfunction

    // Issue one operation starting at the current negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [63:0] exp;
        int lat;
        int bcnt;
        exp = model(op, a, b);
        mdu_if.start = 1'b1;
        mdu_if.op    = op;
        mdu_if.reg_a = a;
        mdu_if.reg_b = b;
        @(negedge clk);
        mdu_if.start = 1'b0;
        mdu_if.wr_hi = 1'b0;
        mdu_if.wr_lo = 1'b0;
        mdu_if.op    = 2'($urandom_range(3));
        mdu_if.reg_a = $urandom;
        mdu_if.reg_b = $urandom;
        lat  = 0;
        bcnt = 0;
        while (!mdu_if.done && lat < 200) begin
            if (mdu_if.busy) bcnt++;
            if (disturb && lat == 5) begin
                mdu_if.start   = 1'b1;
                mdu_if.op      = 2'b01;
                mdu_if.wr_hi   = 1'b1;
                mdu_if.wr_data = 32'h0000_1234;
            end else if (disturb && lat == 6) begin
                mdu_if.start = 1'b0;
                mdu_if.wr_hi = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(W + 1));
        check($sformatf("busy_cycles op%0d", op), 64'(bcnt), 64'(W + 1));
        check("busy_at_done", 64'(mdu_if.busy), 64'd0);
        check($sformatf("hi op%0d a=%h b=%h", op, a, b), 64'(mdu_if.hi), 64'(exp[63:32]));
        check($sformatf("lo op%0d a=%h b=%h", op, a, b), 64'(mdu_if.lo), 64'(exp[31:0]));
`ifdef MDU_DIVZERO_FLAG_EN
        check("div_by_zero", 64'(mdu_if.div_by_zero), 64'(op[1] && b == 32'd0));
`endif
    endtask

    logic [31:0] hi_before;
    int          done_seen;

    initial begin
        mdu_if.start   = 1'b0;
        mdu_if.op      = 2'b00;
        mdu_if.reg_a   = '0;
        mdu_if.reg_b   = '0;
        mdu_if.wr_hi   = 1'b0;
        mdu_if.wr_lo   = 1'b0;
        mdu_if.wr_data = '0;

        repeat (3) @(negedge clk);
        check("reset busy", 64'(mdu_if.busy), 64'd0);
        check("reset done", 64'(mdu_if.done), 64'd0);
        check("reset hi", 64'(mdu_if.hi), 64'd0);
        check("reset lo", 64'(mdu_if.lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back-to-back in each done cycle
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'd7, 32'd0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0);

        @(negedge clk);
        check("done_one_cycle", 64'(mdu_if.done), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        check("div_by_zero_clear", 64'(mdu_if.div_by_zero), 64'd0);
`endif

        // start and MTHI while busy must not disturb the running MULT
        run_op(2'b00, 32'h0001_0003, 32'hFFFF_0000, 1'b1);
        @(negedge clk);
        check("ignored_start", 64'(mdu_if.busy), 64'd0);

        // MTLO when idle, hi untouched
        hi_before      = mdu_if.hi;
        mdu_if.wr_lo   = 1'b1;
        mdu_if.wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        mdu_if.wr_lo = 1'b0;
        check("mtlo lo", 64'(mdu_if.lo), 64'h0000_0000_A5A5_A5A5);
        check("mtlo hi", 64'(mdu_if.hi), 64'(hi_before));

        // MTHI and MTLO together
        mdu_if.wr_hi   = 1'b1;
        mdu_if.wr_lo   = 1'b1;
        mdu_if.wr_data = 32'h5A5A_0F0F;
        @(negedge clk);
        mdu_if.wr_hi = 1'b0;
        mdu_if.wr_lo = 1'b0;
        check("mthi_mtlo hi", 64'(mdu_if.hi), 64'h0000_0000_5A5A_0F0F);
        check("mthi_mtlo lo", 64'(mdu_if.lo), 64'h0000_0000_5A5A_0F0F);

        // Write in the start cycle is overwritten by the result
        mdu_if.wr_hi   = 1'b1;
        mdu_if.wr_data = 32'hDEAD_BEEF;
        run_op(2'b01, 32'd3, 32'd4, 1'b0);

        // Randomized back-to-back stream
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            int          mode;
            rop  = 2'($urandom_range(3));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 5);
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) begin
                ra = $urandom_range(0, 100) - 50;
                rb = $urandom_range(0, 20) - 10;
            end
            run_op(rop, ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of a MULT
        mdu_if.start = 1'b1;
        mdu_if.op    = 2'b00;
        mdu_if.reg_a = 32'h0000_1111;
        mdu_if.reg_b = 32'h0000_2222;
        @(negedge clk);
        mdu_if.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun busy", 64'(mdu_if.busy), 64'd0);
        check("midrun done", 64'(mdu_if.done), 64'd0);
        check("midrun hi", 64'(mdu_if.hi), 64'd0);
        check("midrun lo", 64'(mdu_if.lo), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdu_if.done || mdu_if.busy) done_seen++;
        end
        check("no_done_after_reset", 64'(done_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS datapath, alongside the combinational ALU. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, using a start/busy/done handshake. It also supports direct HI/LO writes (MTHI/MTLO) and continuous HI/LO reads (MFHI/MFLO).

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be >= 4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request operation; sampled only when busy=0.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
reg_a  input  WIDTH  multiplicand / dividend; sampled with start.
reg_b  input  WIDTH  multiplier / divisor; sampled with start.
wr_hi  input  1  MTHI strobe.
wr_lo  input  1  MTLO strobe.
wr_data  input  WIDTH  data for MTHI/MTLO.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; HI/LO hold the new result.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy, done, hi, lo and the counter all 0.
  - An in-flight operation is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge 0: latch op; latch |a| and |b| (signed ops) or the raw values (unsigned ops); latch result sign; counter=0; go to RUN; busy=1 from edge 0.
- RUN, one iteration per edge:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After the WIDTH-th iteration (edge WIDTH), go to FIX.
- FIX, at edge WIDTH+1:
  - Apply two's-complement sign correction.
  - Write hi/lo; done=1 for exactly one cycle; busy=0; go to IDLE.
  - Latency: result visible WIDTH+1 cycles after start is sampled; busy is high for WIDTH+1 cycles.
- Back-to-back: start is accepted in the cycle done is high (busy=0 then).
- start while busy=1: ignored, with no effect on the in-flight operation.
- op/reg_a/reg_b are don't-care except in the cycle start is accepted.
- Multiply:
  - {hi,lo} = full 2*WIDTH product.
  - MULT: signed; product negated if sign(a) XOR sign(b).
  - MULTU: unsigned.
- Divide:
  - lo = quotient, truncated toward zero; hi = remainder, sign follows the dividend (DIV).
  - DIVU: unsigned.
  - DIV MIN / -1: magnitude 2^(WIDTH-1) wraps; lo=MIN, hi=0.
  - Divisor 0, DIV or DIVU: lo = all ones, hi = reg_a as sampled; sign fix bypassed; latency unchanged.
- MTHI/MTLO:
  - busy=0: wr_hi/wr_lo load wr_data into hi/lo at the next edge.
  - busy=1: ignored.
  - wr_hi and wr_lo together: both loaded.
  - Write and start accepted in the same cycle: write applies now; the later result overwrites it.
- hi/lo change only on reset, an accepted write, or the FIX edge.

Optional Feature:
Macro MDU_DIVZERO_FLAG_EN.
- Defined: extra output div_by_zero (1 bit).
  - Set together with done when a DIV/DIVU had divisor 0; cleared the next cycle.
  - Reset value 0.
- Not defined: port absent; divide-by-zero results as above, with no indication.

Test Plan:
- WIDTH=32, reset low mid-RUN of MULT -> busy=0, done=0, hi=lo=0 immediately; no done pulse follows after reset releases.
- MULT a=0xFFFFFFFD (-3), b=5 -> done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Second start issued in the done cycle -> accepted; done again 33 cycles later.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7; with MDU_DIVZERO_FLAG_EN, div_by_zero=1 for exactly the done cycle.
- While busy: pulse start with MULTU and wr_hi with 0x1234 -> both ignored, result unchanged. When idle: wr_lo 0xA5A5A5A5 -> lo=0xA5A5A5A5 next cycle, hi unchanged.
